// File: rtl/writeback_regfile.sv
// Write-back stage register file: selects the WB value, commits it to a
// 32-entry GPR array, serves two bypassed ID read ports and counts commits.
//
// Ports:
//   Clock, Reset (async, active-low)
//   RegWriteIn, MemToRegIn, R_Data_In, ALUResult_In, rDestSelected_In : MEM/WB
//   ReadAddr1/2 -> ReadData1/2 : ID read ports, combinational, write-through
//   WriteData_Out : selected WB value for the forwarding unit
//   WbCount : committed register writes since reset (wraps)
module writeback_regfile #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 5,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   RegWriteIn,
   input  logic                   MemToRegIn,
   input  logic [DATA_WIDTH-1:0]  R_Data_In,
   input  logic [DATA_WIDTH-1:0]  ALUResult_In,
   input  logic [ADDR_WIDTH-1:0]  rDestSelected_In,
   input  logic [ADDR_WIDTH-1:0]  ReadAddr1,
   input  logic [ADDR_WIDTH-1:0]  ReadAddr2,
   output logic [DATA_WIDTH-1:0]  ReadData1,
   output logic [DATA_WIDTH-1:0]  ReadData2,
   output logic [DATA_WIDTH-1:0]  WriteData_Out,
   output logic [COUNT_WIDTH-1:0] WbCount
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]  regs_q [DEPTH];
   logic [DATA_WIDTH-1:0]  regs_d [DEPTH];
   logic [COUNT_WIDTH-1:0] wb_count_q;
   logic [COUNT_WIDTH-1:0] wb_count_d;
   logic                   we_eff;

   assign WriteData_Out = MemToRegIn ? R_Data_In : ALUResult_In;

   // x0 is never a real target: the enable is killed here so that the
   // array entry and the counter both stay untouched.
   assign we_eff = RegWriteIn && (rDestSelected_In != '0);

   always_comb begin
      regs_d     = regs_q;
      wb_count_d = wb_count_q;
      if (we_eff) begin
         regs_d[rDestSelected_In] = WriteData_Out;
         wb_count_d = wb_count_q + COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         wb_count_q <= '0;
      end else begin
         regs_q     <= regs_d;
         wb_count_q <= wb_count_d;
      end
   end

   // Index 0 wins over the bypass so x0 reads zero even mid-write.
   function automatic logic [DATA_WIDTH-1:0] rd_port(
      input logic [ADDR_WIDTH-1:0] a
   );
      if (a == '0) begin
         return '0;
      end else if (we_eff && (a == rDestSelected_In)) begin
         return WriteData_Out;
      end else begin
         return regs_q[a];
      end
   endfunction

   always_comb begin
      ReadData1 = rd_port(ReadAddr1);
      ReadData2 = rd_port(ReadAddr2);
   end

   assign WbCount = wb_count_q;

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface.
- Takes the registered MEM/WB outputs, selects the write-back value (memory read data or ALU result) and commits it to a 32-entry general-purpose register file.
- Serves the two ID-stage read ports. A same-cycle write-through bypass lets ID see a value being written in that cycle with no extra stall.
- Also exposes the selected write-back value for the forwarding unit, and a retired-write counter for debug/performance.

Parameters:
- DATA_WIDTH, 32, width of register entries and data paths.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH (32 entries).
- COUNT_WIDTH, 32, width of the retired-write counter.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- RegWriteIn  input  1  write enable from MEM/WB.
- MemToRegIn  input  1  1 = write R_Data_In, 0 = write ALUResult_In.
- R_Data_In  input  DATA_WIDTH  data-memory read value from MEM/WB.
- ALUResult_In  input  DATA_WIDTH  ALU result from MEM/WB.
- rDestSelected_In  input  ADDR_WIDTH  destination register index from MEM/WB.
- ReadAddr1  input  ADDR_WIDTH  ID read port 1 index (rs).
- ReadAddr2  input  ADDR_WIDTH  ID read port 2 index (rt).
- ReadData1  output  DATA_WIDTH  read port 1 data, combinational.
- ReadData2  output  DATA_WIDTH  read port 2 data, combinational.
- WriteData_Out  output  DATA_WIDTH  selected write-back value, combinational, to the forwarding unit.
- WbCount  output  COUNT_WIDTH  number of committed register writes since reset.

Behaviour:
- WriteData_Out = MemToRegIn ? R_Data_In : ALUResult_In. Purely combinational; valid every cycle regardless of RegWriteIn.
- Commit condition: WeEff = RegWriteIn && (rDestSelected_In != 0).
- Write: on rising Clock with WeEff, regs[rDestSelected_In] <= WriteData_Out.
- Register 0:
  - Hardwired to zero and never written.
  - Reads of index 0 always return 0, including during bypass.
  - RegWriteIn with rDest = 0 is a no-op and does not increment WbCount.
- Read ports, per port, combinational:
  - If index == 0: output 0.
  - Else if WeEff and index == rDestSelected_In: output WriteData_Out (write-through bypass).
  - Else: output regs[index].
- Both read ports may address the same register, or the write target, simultaneously; each resolves independently with the same rule.
- WbCount:
  - Increments by 1 on each rising Clock where WeEff = 1.
  - Wraps modulo 2**COUNT_WIDTH (all-ones + 1 -> 0), no saturation.
- Reset:
  - While Reset = 0, asynchronously and immediately clears all 32 entries and WbCount to 0.
  - Takes priority over any write in the same cycle; a write presented while Reset is low is lost.
  - Deassertion is synchronous-safe: the first write can commit on the first rising edge after Reset returns high.
- Reset-state outputs:
  - ReadData1 = ReadData2 = 0 unless a bypass is active.
  - WbCount = 0.
  - WriteData_Out follows its inputs (combinational).
- Latency:
  - Write visible through the array on the cycle after the commit edge.
  - Visible through the bypass in the same cycle.
  - Zero-cycle read latency.
- X-safety: with RegWriteIn = 0, rDest/data inputs may be X with no state change.

Test Plan:
- Reset with Reset = 0 mid-run after writing regs 5 and 9 -> ReadData of 5 and 9 read 0 immediately (before the next edge), WbCount = 0.
- RegWriteIn = 1, MemToRegIn = 0, ALUResult_In = 0x0000_00AA, rDest = 7; then RegWriteIn = 0, ReadAddr1 = 7 -> ReadData1 = 0x0000_00AA and WbCount = 1. Repeat with MemToRegIn = 1, R_Data_In = 0xDEAD_BEEF, rDest = 7 -> ReadData1 = 0xDEAD_BEEF.
- Same-cycle bypass: reg 3 = 0x11; RegWriteIn = 1, rDest = 3, ALUResult_In = 0x22, ReadAddr1 = ReadAddr2 = 3 -> both ReadData = 0x22 before the edge and 0x22 after it. ReadAddr2 = 4 in the same cycle -> old reg 4 value.
- Write to reg 0: RegWriteIn = 1, rDest = 0, ALUResult_In = 0xFFFF_FFFF, ReadAddr1 = 0 -> ReadData1 = 0 in the same cycle and after, WbCount unchanged.
- Counter wrap with COUNT_WIDTH = 4 override: 17 valid writes to rDest = 1 -> WbCount reads 1. A cycle with RegWriteIn = 0 -> WbCount holds.
- Reset asserted in the same cycle as RegWriteIn = 1, rDest = 12, ALUResult_In = 0x55 -> after release reg 12 = 0, WbCount = 0.
